// File: rtl/audio_nios_pio_led_blink.sv
// Avalon-MM LED PIO with DATA/SET/CLEAR registers; optional shared-phase blink engine via AUDIO_NIOS_PIO_LED_BLINK_EN.
// Zero-wait combinational reads, writes land on the next rising edge, the slave never stalls the bus.
module audio_nios_pio_led_blink #(
   parameter int unsigned      WIDTH       = 4,
   parameter int unsigned      PERIOD_W    = 24,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);
   localparam logic [2:0] A_DATA  = 3'd0;
   localparam logic [2:0] A_SET   = 3'd4;
   localparam logic [2:0] A_CLEAR = 3'd5;

   logic             wr;
   logic [WIDTH-1:0] wr_ch;
   logic [WIDTH-1:0] data_q, data_d;
   logic             unused_wd;

   assign wr        = chipselect & ~write_n;
   assign wr_ch     = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   always_comb begin
      data_d = data_q;
      if (wr) begin
         case (address)
            A_DATA:  data_d = wr_ch;
            A_SET:   data_d = data_q | wr_ch;
            A_CLEAR: data_d = data_q & ~wr_ch;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) data_q <= RESET_VALUE;
      else          data_q <= data_d;
   end

`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
   localparam logic [2:0] A_BLINK  = 3'd1;
   localparam logic [2:0] A_PERIOD = 3'd2;

   logic [WIDTH-1:0]    blink_en_q, blink_en_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;

   always_comb begin
      blink_en_d = blink_en_q;
      period_d   = period_q;
      // Compare before increment so an all-ones period wraps cleanly.
      if (cnt_q == period_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + 1'b1;
         phase_d = phase_q;
      end
      if (wr && address == A_BLINK) blink_en_d = wr_ch;
      // A period write restarts the blink cycle and overrides a coincident terminal count.
      if (wr && address == A_PERIOD) begin
         period_d = writedata[PERIOD_W-1:0];
         cnt_d    = '0;
         phase_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_en_q <= '0;
         period_q   <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
      end else begin
         blink_en_q <= blink_en_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:   readdata[WIDTH-1:0]    = data_q;
         A_BLINK:  readdata[WIDTH-1:0]    = blink_en_q;
         A_PERIOD: readdata[PERIOD_W-1:0] = period_q;
         default:  ;
      endcase
   end

   assign out_port = data_q & (~blink_en_q | {WIDTH{phase_q}});
`else
   always_comb begin
      readdata = '0;
      if (address == A_DATA) readdata[WIDTH-1:0] = data_q;
   end

   assign out_port = data_q;
`endif

endmodule

// File: tb/tb_audio_nios_pio_led_blink.sv
// Randomized bench for audio_nios_pio_led_blink with an elapsed-time blink model and directed anchor checks.
module tb_audio_nios_pio_led_blink;
   localparam int         W  = 4;
   localparam int         PW = 24;
   localparam logic [3:0] RV = 4'b1010;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  out_port;

   int total = 0;
   int bad   = 0;

   // Reference state: register contents plus edges elapsed since the blink cycle was last restarted.
   logic [3:0]  m_data   = RV;
   logic [3:0]  m_ben    = '0;
   logic [23:0] m_period = '0;
   longint      m_elapsed = 0;

   audio_nios_pio_led_blink #(.WIDTH(W), .PERIOD_W(PW), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_data = RV; m_ben = '0; m_period = '0; m_elapsed = 0;
      end else begin
         m_elapsed++;
         if (chipselect && !write_n) begin
            case (address)
               3'd0: m_data = writedata[3:0];
               3'd4: m_data = m_data | writedata[3:0];
               3'd5: m_data = m_data & ~writedata[3:0];
`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
               3'd1: m_ben = writedata[3:0];
               3'd2: begin m_period = writedata[23:0]; m_elapsed = 0; end
`endif
               default: ;
            endcase
         end
      end
   end

   function automatic logic [3:0] exp_out();
      logic [3:0] r;
      logic       ph;
      ph = ((m_elapsed / (longint'(m_period) + 1)) % 2) == 1;
      for (int i = 0; i < 4; i++) r[i] = m_data[i] & (m_ben[i] ? ph : 1'b1);
      return r;
   endfunction

   function automatic logic [31:0] exp_rd();
      logic [31:0] r;
      r = '0;
      case (address)
         3'd0: r[3:0] = m_data;
`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
         3'd1: r[3:0] = m_ben;
         3'd2: r[23:0] = m_period;
`endif
         default: ;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      chk("out_port_model", {28'd0, out_port}, {28'd0, exp_out()});
      chk("readdata_model", readdata, exp_rd());
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
      @(posedge clk); #1;
      address = a;
      #1;
      chk(name, readdata, exp);
   endtask

   initial begin
      reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      #1 reset_n = 1'b0;
      #1 chk("reset_out", {28'd0, out_port}, 32'h0000000A);
      rd_chk("reset_rd0", 3'd0, 32'h0000000A);
      rd_chk("reset_rd1", 3'd1, 32'h0);
      rd_chk("reset_rd2", 3'd2, 32'h0);
      @(posedge clk); #3 reset_n = 1'b1;

      bus_write(3'd0, 32'hFFFF_FFF5);
      rd_chk("data_rd", 3'd0, 32'h5);
      bus_write(3'd4, 32'h8);
      rd_chk("set_rd", 3'd0, 32'hD);
      bus_write(3'd5, 32'h1);
      rd_chk("clear_rd", 3'd0, 32'hC);
      chk("clear_out", {28'd0, out_port}, 32'hC);
      rd_chk("set_addr_rd", 3'd4, 32'h0);
      rd_chk("clear_addr_rd", 3'd5, 32'h0);

`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
      bus_write(3'd0, 32'hF);
      bus_write(3'd1, 32'h3);
      bus_write(3'd2, 32'h2);
      for (int k = 0; k < 9; k++) begin
         chk("blink_p2", {28'd0, out_port}, (((k / 3) % 2) == 1) ? 32'hF : 32'hC);
         @(posedge clk); #1;
      end

      bus_write(3'd0, 32'h1);
      bus_write(3'd1, 32'h1);
      bus_write(3'd2, 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk("blink_p0", {28'd0, out_port}, (k % 2 == 1) ? 32'h1 : 32'h0);
         @(posedge clk); #1;
      end
      bus_write(3'd2, 32'h5);
      for (int k = 0; k < 7; k++) begin
         chk("period_on_toggle", {28'd0, out_port}, (k == 6) ? 32'h1 : 32'h0);
         @(posedge clk); #1;
      end

      bus_write(3'd0, 32'hF);
      bus_write(3'd1, 32'hF);
      bus_write(3'd2, 32'h9);
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_reset_out", {28'd0, out_port}, 32'h0);
      reset_n = 1'b0;
      #1 chk("async_reset_out", {28'd0, out_port}, 32'h0000000A);
      @(posedge clk); #3 reset_n = 1'b1;
      rd_chk("post_reset_rd0", 3'd0, 32'hA);
      rd_chk("post_reset_rd1", 3'd1, 32'h0);
      rd_chk("post_reset_rd2", 3'd2, 32'h0);
      for (int k = 0; k < 8; k++) begin
         chk("post_reset_steady", {28'd0, out_port}, 32'hA);
         @(posedge clk); #1;
      end
`else
      bus_write(3'd1, 32'hF);
      bus_write(3'd2, 32'h7);
      bus_write(3'd0, 32'h6);
      rd_chk("noblink_rd1", 3'd1, 32'h0);
      rd_chk("noblink_rd2", 3'd2, 32'h0);
      for (int k = 0; k < 10; k++) begin
         chk("noblink_steady", {28'd0, out_port}, 32'h6);
         @(posedge clk); #1;
      end
`endif

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 399) == 0) begin
            chipselect = 1'b0; write_n = 1'b1;
            reset_n = 1'b0;
            @(posedge clk); #3 reset_n = 1'b1;
         end else begin
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if (address == 3'd2)
               writedata[23:0] = ($urandom_range(0, 9) == 0) ? 24'($urandom) : 24'($urandom_range(0, 6));
         end
      end

      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/audio_nios_pio_led_blink.md
AUDIO_NIOS_PIO_LED_BLINK -- requirements
Module: audio_nios_pio_led_blink

Interface
REQ-001 Parameter WIDTH, default 4, number of output channels (legal 1..32).
REQ-002 Parameter PERIOD_W, default 24, width of the blink half-period register and counter (legal 1..32).
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit reset value of the DATA register.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; write = chipselect && !write_n.
REQ-009 writedata  input  32  write data; bits [31:WIDTH] ignored for channel registers.
REQ-010 readdata  output  32  read data; unused upper bits read 0.
REQ-011 out_port  output  WIDTH  LED drive.

Function
REQ-012 Register map SHALL be: 0 DATA (R/W), 1 BLINK_EN (R/W), 2 PERIOD (R/W, PERIOD_W bits), 3 reserved, 4 SET (W), 5 CLEAR (W), 6-7 reserved.
REQ-013 Write to DATA SHALL load data_out <= writedata[WIDTH-1:0] at the next rising edge.
REQ-014 Write to SET SHALL perform data_out <= data_out | writedata[WIDTH-1:0]; write to CLEAR SHALL perform data_out <= data_out & ~writedata[WIDTH-1:0].
REQ-015 Write to BLINK_EN SHALL load blink_en <= writedata[WIDTH-1:0].
REQ-016 Write to PERIOD SHALL load period <= writedata[PERIOD_W-1:0] and in the same edge force cnt <= 0 and phase <= 0.
REQ-017 Writes to reserved addresses SHALL have no effect.
REQ-018 readdata SHALL be combinational (zero wait states, read latency 0): address 0 -> data_out, 1 -> blink_en, 2 -> period, all other addresses -> 0; zero-extended to 32 bits.
REQ-019 Blink counter cnt (PERIOD_W bits) SHALL free-run: if cnt == period then cnt <= 0 and phase <= ~phase, else cnt <= cnt + 1.
REQ-020 Phase SHALL therefore toggle every period+1 clocks; period = 0 toggles every clock; period = all-ones SHALL not overflow (comparison precedes increment).
REQ-021 A PERIOD write coinciding with a terminal count SHALL win (cnt = 0, phase = 0, no toggle).
REQ-022 out_port[i] SHALL equal data_out[i] & (blink_en[i] ? phase : 1), purely combinational from registers (no glitch paths from bus inputs).
REQ-023 All blinking channels SHALL share one phase and remain mutually synchronous.
REQ-024 Write to DATA/SET/CLEAR SHALL not disturb cnt or phase.

Reset
REQ-025 While reset_n = 0: data_out = RESET_VALUE, blink_en = 0, period = 0, cnt = 0, phase = 0, hence out_port = RESET_VALUE immediately (asynchronous).
REQ-026 Reset asserted mid-count SHALL clear cnt and phase; counting resumes from 0 on the first edge after deassertion.
REQ-027 readdata SHALL reflect reset register values during reset.

Configuration
REQ-028 Macro AUDIO_NIOS_PIO_LED_BLINK_EN defined: blink logic (blink_en, period, cnt, phase) present as above.
REQ-029 Macro undefined: blink logic SHALL be absent; addresses 1 and 2 read 0 and ignore writes; out_port = data_out; DATA/SET/CLEAR unchanged.

Verification
REQ-030 Reset with RESET_VALUE=4'b1010 -> out_port = 4'b1010, reads of addr 0/1/2 = 0x0000000A/0/0.
REQ-031 Write DATA=0x5, SET=0x8, CLEAR=0x1 -> readback addr 0 = 0xC after each final edge; out_port = 4'b1100; addr 4/5 read 0.
REQ-032 DATA=0xF, BLINK_EN=0x3, PERIOD=2 -> out_port[1:0] toggle every 3 clocks starting low, out_port[3:2] steady 1.
REQ-033 PERIOD=0 with BLINK_EN=0x1, DATA=0x1 -> out_port[0] toggles every clock; then PERIOD=5 written on a toggle edge -> phase 0, next toggle 6 clocks later.
REQ-034 Assert reset_n low mid-blink (cnt = 3, PERIOD = 9) -> out_port returns to RESET_VALUE asynchronously; after release all registers 0, no blinking.
REQ-035 Build without AUDIO_NIOS_PIO_LED_BLINK_EN: write BLINK_EN=0xF, PERIOD=7, DATA=0x6 -> addr 1/2 read 0, out_port = 4'b0110 steady.
